// File: rtl/sub4_response_checker.sv
`default_nettype none
//============================================================================
// Module      : sub4_response_checker
// Description : Receiving-end response checker for a 4-bit ripple subtractor
//               (S = A + ~B + 1). Vectors {a,b,s,cout} arrive over a
//               valid/ready handshake; the checker recomputes the expected
//               difference and carry, counts vectors and mismatches,
//               captures the first failing vector and reports pass/fail
//               once EXP_VECTORS vectors have been accepted.
//
// Ports       : clk, rst_n (async, active low)
//               start                  - run request (IDLE/DONE only)
//               in_valid / in_ready    - vector handshake
//               a, b, s, cout          - operands and DUT result
//               busy, done, pass       - run status
//               vec_cnt, err_cnt       - vectors checked / mismatches (sat.)
//               fail_valid, fail_a/b/s/cout - first failing vector
//
// Options     : CHK_HALT_ON_FAIL_EN - when defined, the first mismatch ends
//               the run immediately (RUN->DONE on that edge).
//
// Revision    : 1.0 - initial release
//============================================================================
module sub4_response_checker #(
    parameter int WIDTH       = 4,
    parameter int CNT_W       = 16,
    parameter int EXP_VECTORS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_s,
    output logic             fail_cout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // vec_cnt value held just before the final accept of a run
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(EXP_VECTORS - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_pass;
    logic             r_fail_valid;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic [WIDTH-1:0] r_fail_s;
    logic             r_fail_cout;

    logic [WIDTH:0]   w_expected;
    logic             w_mismatch;
    logic             w_xfer;
    logic             w_last;
    logic             w_finish;
    logic             w_restart;

    // Reference model of the subtractor, carry-out included (1 = no borrow)
    assign w_expected = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_mismatch = (w_expected != {cout, s});

    assign w_xfer    = in_valid && (r_state == ST_RUN);
    assign w_last    = (r_vec_cnt == c_last_idx);
    assign w_restart = start && (r_state != ST_RUN);

`ifdef CHK_HALT_ON_FAIL_EN
    assign w_finish = w_xfer && (w_last || w_mismatch);
`else
    assign w_finish = w_xfer && w_last;
`endif

    //------------------------------------------------------------------------
    // FSM
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)    w_state_nxt = ST_RUN;
            ST_RUN:  if (w_finish) w_state_nxt = ST_DONE;
            ST_DONE: if (start)    w_state_nxt = ST_RUN;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    //------------------------------------------------------------------------
    // Counters, verdict and first-fail capture
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_cnt    <= '0;
            r_err_cnt    <= '0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_s     <= '0;
            r_fail_cout  <= 1'b0;
        end else if (w_restart) begin
            r_vec_cnt    <= '0;
            r_err_cnt    <= '0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_s     <= '0;
            r_fail_cout  <= 1'b0;
        end else if (w_xfer) begin
            r_vec_cnt <= r_vec_cnt + 1'b1;
            if (w_mismatch) begin
                if (r_err_cnt != {CNT_W{1'b1}}) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (!r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_a     <= a;
                    r_fail_b     <= b;
                    r_fail_s     <= s;
                    r_fail_cout  <= cout;
                end
            end
            // fail_valid doubles as the "any mismatch so far" flag; the
            // current vector is folded in because its capture lands on the
            // same edge.
            if (w_finish) begin
                r_pass <= !(r_fail_valid || w_mismatch);
            end
        end
    end

    assign in_ready   = (r_state == ST_RUN);
    assign busy       = (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign pass       = r_pass;
    assign vec_cnt    = r_vec_cnt;
    assign err_cnt    = r_err_cnt;
    assign fail_valid = r_fail_valid;
    assign fail_a     = r_fail_a;
    assign fail_b     = r_fail_b;
    assign fail_s     = r_fail_s;
    assign fail_cout  = r_fail_cout;

endmodule
`default_nettype wire
